// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU-select decoder and the iterative MDU:
// ALU select codes, control-unit classes, funct codes, result-source and MDU state enums.
package alu_ctrl_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] UCON_LWSW  = 3'b000;
    localparam logic [2:0] UCON_BEQ   = 3'b001;
    localparam logic [2:0] UCON_RTYPE = 3'b010;
    localparam logic [2:0] UCON_ADDI  = 3'b011;
    localparam logic [2:0] UCON_ANDI  = 3'b100;
    localparam logic [2:0] UCON_ORI   = 3'b101;
    localparam logic [2:0] UCON_SLTI  = 3'b110;
    localparam logic [2:0] UCON_ILL   = 3'b111;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_HI  = 2'b01,
        RES_LO  = 2'b10
    } res_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_FIX  = 2'b11
    } md_state_e;

    // funct[1:0] of the four mult/div encodings: bit1 = divide, bit0 = unsigned
    function automatic logic is_md_funct(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    function automatic logic is_hilo_read(input logic [5:0] f);
        return (f == FN_MFHI) || (f == FN_MFLO);
    endfunction

endpackage

// File: rtl/alu_mdu_core.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// sign fix-up, HI/LO registers and a one-cycle done pulse.
import alu_ctrl_pkg::*;

module alu_mdu_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CNT_W = $clog2(DATA_W);

    md_state_e             state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  last;
    logic [2*DATA_W-1:0]   acc, mul_step, div_step, fix_val;
    logic [DATA_W-1:0]     acc_hi, acc_lo, opnd;
    logic                  is_mul, neg_hi, neg_lo, dz;
    logic                  is_div, sgn_a, sgn_b, div_zero;
    logic [DATA_W-1:0]     mag_a, mag_b;
    logic [DATA_W:0]       mul_sum, div_shift, div_diff;

    assign acc_hi = acc[2*DATA_W-1:DATA_W];
    assign acc_lo = acc[DATA_W-1:0];
    assign last   = (cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        is_div   = op[1];
        sgn_a    = ~op[0] & a[DATA_W-1];
        sgn_b    = ~op[0] & b[DATA_W-1];
        mag_a    = sgn_a ? -a : a;
        mag_b    = sgn_b ? -b : b;
        div_zero = is_div & (b == '0);
    end

    // the upper half doubles as the partial product (MUL) or partial remainder (DIV)
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step  = {mul_sum, acc_lo[DATA_W-1:1]};
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_step  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc_lo[DATA_W-2:0], 1'b0}
                                     : {div_diff[DATA_W-1:0],  acc_lo[DATA_W-2:0], 1'b1};
        if (dz)
            fix_val = acc;
        else if (is_mul)
            fix_val = neg_lo ? -acc : acc;
        else
            fix_val = {neg_hi ? -acc_hi : acc_hi, neg_lo ? -acc_lo : acc_lo};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == MD_FIX);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = div_zero ? MD_FIX : (is_div ? MD_DIV : MD_MUL);
            MD_MUL,
            MD_DIV:  if (flush) state_nxt = MD_IDLE;
                     else if (last) state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != MD_IDLE);
    end

    always_ff @(posedge clk) begin
        if (state == MD_IDLE && start) begin
            cnt    <= '0;
            is_mul <= ~is_div;
            neg_lo <= sgn_a ^ sgn_b;
            neg_hi <= sgn_a;
            dz     <= div_zero;
            if (div_zero) begin
                acc <= {a, {DATA_W{1'b1}}};
            end else if (is_div) begin
                acc  <= {{DATA_W{1'b0}}, mag_a};
                opnd <= mag_b;
            end else begin
                acc  <= {{DATA_W{1'b0}}, mag_b};
                opnd <= mag_a;
            end
        end else if (state == MD_MUL) begin
            acc <= mul_step;
            cnt <= cnt + 1'b1;
        end else if (state == MD_DIV) begin
            acc <= div_step;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == MD_FIX) begin
            hi <= fix_val[2*DATA_W-1:DATA_W];
            lo <= fix_val[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/alu_mdu_control.sv
// Registered ALU-select decoder with stall handshake and optional HI/LO multiply/divide.
// Define ALU_MDU_EN to include the MDU; without it mult/div/mfhi/mflo decode as illegal.
import alu_ctrl_pkg::*;

module alu_mdu_control #(
    parameter int         DATA_W      = 32,
    parameter logic [2:0] ILLEGAL_SEL = 3'b011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [2:0]        ucon_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_val_i,
    input  logic [DATA_W-1:0] rt_val_i,
    input  logic              flush_i,
    output logic [2:0]        alu_sel_o,
    output logic [1:0]        res_sel_o,
    output logic              illegal_o,
    output logic              stall_o,
    output logic              busy_o,
    output logic              md_done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    logic [2:0] dec_sel;
    res_sel_e   dec_res;
    logic       dec_ill;
    logic       accept;
`ifdef ALU_MDU_EN
    logic       dec_md;
`endif

    always_comb begin
        dec_sel = ILLEGAL_SEL;
        dec_res = RES_ALU;
        dec_ill = 1'b0;
`ifdef ALU_MDU_EN
        dec_md  = 1'b0;
`endif
        case (ucon_i)
            UCON_LWSW: dec_sel = ALU_ADD;
            UCON_BEQ:  dec_sel = ALU_SUB;
            UCON_ADDI: dec_sel = ALU_ADD;
            UCON_ANDI: dec_sel = ALU_AND;
            UCON_ORI:  dec_sel = ALU_OR;
            UCON_SLTI: dec_sel = ALU_SLT;
            UCON_RTYPE: begin
                case (funct_i)
                    FN_ADD:  dec_sel = ALU_ADD;
                    FN_SUB:  dec_sel = ALU_SUB;
                    FN_AND:  dec_sel = ALU_AND;
                    FN_OR:   dec_sel = ALU_OR;
                    FN_SLT:  dec_sel = ALU_SLT;
                    FN_SLL:  dec_sel = ALU_NOP;
                    FN_XOR:  dec_sel = ALU_XOR;
                    FN_NOR:  dec_sel = ALU_NOR;
`ifdef ALU_MDU_EN
                    FN_MFHI: dec_res = RES_HI;
                    FN_MFLO: dec_res = RES_LO;
                    FN_MULT, FN_MULTU,
                    FN_DIV,  FN_DIVU: dec_md = 1'b1;
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

`ifdef ALU_MDU_EN
    // only HI/LO readers and new mult/div ops must wait for the unit
    assign stall_o = valid_i & busy_o & (ucon_i == UCON_RTYPE)
                   & (is_md_funct(funct_i) | is_hilo_read(funct_i));
`else
    assign stall_o = 1'b0;
`endif

    assign accept = valid_i & ~stall_o & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_sel_o <= ILLEGAL_SEL;
            res_sel_o <= RES_ALU;
            illegal_o <= 1'b0;
        end else if (accept) begin
            alu_sel_o <= dec_sel;
            res_sel_o <= dec_res;
            illegal_o <= dec_ill;
        end else begin
            alu_sel_o <= ILLEGAL_SEL;
            res_sel_o <= RES_ALU;
            illegal_o <= 1'b0;
        end
    end

`ifdef ALU_MDU_EN
    alu_mdu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (accept & dec_md),
        .op    (funct_i[1:0]),
        .a     (rs_val_i),
        .b     (rt_val_i),
        .flush (flush_i),
        .busy  (busy_o),
        .done  (md_done_o),
        .hi    (hi_o),
        .lo    (lo_o)
    );
`else
    logic unused_operands;
    assign unused_operands = ^{rs_val_i, rt_val_i};
    assign busy_o    = 1'b0;
    assign md_done_o = 1'b0;
    assign hi_o      = '0;
    assign lo_o      = '0;
`endif

endmodule

// File: tb/tb_alu_mdu_control.sv
// Scoreboard bench for alu_mdu_control: decode expectations and HI/LO results are
// queued at issue time and compared when the DUT produces them.
module tb_alu_mdu_control;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, valid_i, flush_i;
    logic [2:0]    ucon_i;
    logic [5:0]    funct_i;
    logic [W-1:0]  rs_val_i, rt_val_i;
    logic [2:0]    alu_sel_o;
    logic [1:0]    res_sel_o;
    logic          illegal_o, stall_o, busy_o, md_done_o;
    logic [W-1:0]  hi_o, lo_o;

    always #5 clk = ~clk;

    alu_mdu_control #(.DATA_W(W), .ILLEGAL_SEL(3'b011)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ucon_i(ucon_i), .funct_i(funct_i),
        .rs_val_i(rs_val_i), .rt_val_i(rt_val_i), .flush_i(flush_i),
        .alu_sel_o(alu_sel_o), .res_sel_o(res_sel_o), .illegal_o(illegal_o),
        .stall_o(stall_o), .busy_o(busy_o), .md_done_o(md_done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic [1:0] res;
        logic       ill;
    } dec_exp_t;

    dec_exp_t       dec_q[$];
    logic [2*W-1:0] md_q[$];
    logic [2*W-1:0] last_md;
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dec_issue(input string tag, input logic [2:0] u, input logic [5:0] f,
                             input logic fl, input logic [2:0] sel, input logic [1:0] res,
                             input logic ill);
        dec_exp_t e;
        ucon_i  = u;
        funct_i = f;
        flush_i = fl;
        valid_i = 1'b1;
        dec_q.push_back({sel, res, ill});
        step();
        valid_i = 1'b0;
        flush_i = 1'b0;
        e = dec_q.pop_front();
        check_eq({tag, "/alu_sel"}, alu_sel_o, e.sel);
        check_eq({tag, "/res_sel"}, res_sel_o, e.res);
        check_eq({tag, "/illegal"}, illegal_o, e.ill);
    endtask

    function automatic logic [63:0] md_model(input logic [5:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0]        ua, ub, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f[1:0])
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            2'b10: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic md_start(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic push);
        ucon_i   = 3'b010;
        funct_i  = f;
        rs_val_i = a;
        rt_val_i = b;
        valid_i  = 1'b1;
        if (push) md_q.push_back(md_model(f, a, b));
        step();
        valid_i = 1'b0;
        check_eq({tag, "/start_sel"}, alu_sel_o, 3'b011);
        check_eq({tag, "/start_ill"}, illegal_o, 1'b0);
    endtask

    task automatic md_result(input string tag);
        check_eq({tag, "/queue"}, md_q.size(), 1);
        if (md_q.size() > 0) begin
            last_md = md_q.pop_front();
            check_eq({tag, "/hi"}, hi_o, last_md[2*W-1:W]);
            check_eq({tag, "/lo"}, lo_o, last_md[W-1:0]);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_busy);
        int n = 0;
        while (busy_o && n < 200) begin
            n++;
            step();
        end
        check_eq({tag, "/busy_cycles"}, n, exp_busy);
        check_eq({tag, "/done_pulse"}, md_done_o, 1'b1);
        md_result(tag);
        step();
        check_eq({tag, "/done_low"}, md_done_o, 1'b0);
    endtask

    task automatic decode_table();
        dec_issue("nor",   3'b010, 6'b100111, 1'b0, 3'b101, 2'b00, 1'b0);
        dec_issue("ucon7", 3'b111, 6'b100000, 1'b0, 3'b011, 2'b00, 1'b1);
        dec_issue("lwsw",  3'b000, 6'b000000, 1'b0, 3'b010, 2'b00, 1'b0);
        dec_issue("beq",   3'b001, 6'b000000, 1'b0, 3'b110, 2'b00, 1'b0);
        dec_issue("addi",  3'b011, 6'b000000, 1'b0, 3'b010, 2'b00, 1'b0);
        dec_issue("andi",  3'b100, 6'b000000, 1'b0, 3'b000, 2'b00, 1'b0);
        dec_issue("ori",   3'b101, 6'b000000, 1'b0, 3'b001, 2'b00, 1'b0);
        dec_issue("slti",  3'b110, 6'b000000, 1'b0, 3'b111, 2'b00, 1'b0);
        dec_issue("add",   3'b010, 6'b100000, 1'b0, 3'b010, 2'b00, 1'b0);
        dec_issue("sub",   3'b010, 6'b100010, 1'b0, 3'b110, 2'b00, 1'b0);
        dec_issue("and",   3'b010, 6'b100100, 1'b0, 3'b000, 2'b00, 1'b0);
        dec_issue("or",    3'b010, 6'b100101, 1'b0, 3'b001, 2'b00, 1'b0);
        dec_issue("slt",   3'b010, 6'b101010, 1'b0, 3'b111, 2'b00, 1'b0);
        dec_issue("sll",   3'b010, 6'b000000, 1'b0, 3'b011, 2'b00, 1'b0);
        dec_issue("xor",   3'b010, 6'b100110, 1'b0, 3'b100, 2'b00, 1'b0);
        dec_issue("badfn", 3'b010, 6'b111111, 1'b0, 3'b011, 2'b00, 1'b1);
        dec_issue("idle",  3'b010, 6'b100000, 1'b0, 3'b010, 2'b00, 1'b0);
        valid_i = 1'b0;
        step();
        check_eq("novalid/alu_sel", alu_sel_o, 3'b011);
        dec_issue("flush_idle", 3'b010, 6'b100000, 1'b1, 3'b011, 2'b00, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        ucon_i = '0; funct_i = '0; rs_val_i = '0; rt_val_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst/alu_sel", alu_sel_o, 3'b011);
        check_eq("rst/res_sel", res_sel_o, 2'b00);
        check_eq("rst/illegal", illegal_o, 1'b0);
        check_eq("rst/busy", busy_o, 1'b0);
        check_eq("rst/done", md_done_o, 1'b0);
        check_eq("rst/hi", hi_o, '0);
        check_eq("rst/lo", lo_o, '0);

        decode_table();

`ifdef ALU_MDU_EN
        dec_issue("mfhi_idle", 3'b010, 6'b010000, 1'b0, 3'b011, 2'b01, 1'b0);
        dec_issue("mflo_idle", 3'b010, 6'b010010, 1'b0, 3'b011, 2'b10, 1'b0);

        md_start("mult", 6'b011000, 32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_done("mult", 33);
        md_start("div", 6'b011010, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("div", 33);
        md_start("divu0", 6'b011011, 32'd7, 32'd0, 1'b1);
        wait_done("divu0", 1);
        md_start("divovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("divovf", 33);
        md_start("multu", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("multu", 33);
        md_start("div_negb", 6'b011010, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done("div_negb", 33);
        md_start("divu", 6'b011011, 32'd100, 32'd7, 1'b1);
        wait_done("divu", 33);

        begin
            int n = 0;
            md_start("stall", 6'b011000, 32'hFFFF_FFFE, 32'h4000_0000, 1'b1);
            repeat (4) step();
            ucon_i = 3'b010; funct_i = 6'b010000; valid_i = 1'b1;
            #1;
            while (stall_o && n < 200) begin
                n++;
                @(posedge clk);
                #2;
            end
            check_eq("stall/cycles", n, 29);
            check_eq("stall/done_at_release", md_done_o, 1'b1);
            md_result("stall");
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            check_eq("stall/mfhi_res", res_sel_o, 2'b01);
            check_eq("stall/mfhi_ill", illegal_o, 1'b0);
        end

        md_start("add_busy", 6'b011001, 32'd12345, 32'd678, 1'b1);
        ucon_i = 3'b010; funct_i = 6'b100000; valid_i = 1'b1;
        #1;
        check_eq("add_busy/stall", stall_o, 1'b0);
        step();
        valid_i = 1'b0;
        check_eq("add_busy/alu_sel", alu_sel_o, 3'b010);
        wait_done("add_busy", 32);

        begin
            int seen = 0;
            md_start("flush", 6'b011000, 32'd99, 32'd3, 1'b0);
            repeat (9) step();
            check_eq("flush/busy_before", busy_o, 1'b1);
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
            check_eq("flush/busy_after", busy_o, 1'b0);
            for (int i = 0; i < 4; i++) begin
                if (md_done_o) seen++;
                step();
            end
            check_eq("flush/no_done", seen, 0);
            check_eq("flush/hi_hold", hi_o, last_md[2*W-1:W]);
            check_eq("flush/lo_hold", lo_o, last_md[W-1:0]);
        end

        md_start("rst_div", 6'b011010, 32'd1000, 32'd3, 1'b0);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_div/busy", busy_o, 1'b0);
        check_eq("rst_div/hi", hi_o, '0);
        check_eq("rst_div/lo", lo_o, '0);
`else
        ucon_i = 3'b010; funct_i = 6'b011000; rs_val_i = 32'd5; rt_val_i = 32'd6;
        valid_i = 1'b1;
        #1;
        check_eq("nomdu/stall", stall_o, 1'b0);
        dec_issue("nomdu_mult", 3'b010, 6'b011000, 1'b0, 3'b011, 2'b00, 1'b1);
        check_eq("nomdu/busy", busy_o, 1'b0);
        check_eq("nomdu/hi", hi_o, '0);
        check_eq("nomdu/lo", lo_o, '0);
        check_eq("nomdu/done", md_done_o, 1'b0);
        dec_issue("nomdu_div",  3'b010, 6'b011010, 1'b0, 3'b011, 2'b00, 1'b1);
        dec_issue("nomdu_mfhi", 3'b010, 6'b010000, 1'b0, 3'b011, 2'b00, 1'b1);
        dec_issue("nomdu_mflo", 3'b010, 6'b010010, 1'b0, 3'b011, 2'b00, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
